// File: rtl/o_buft_bus_sched_if.sv
// Bundle between fabric requesters and the O_BUFT pad scheduler.
// Requesters raise req[k] and keep it high for as long as they want the pad.
// gnt[k] answers one cycle after the registered request is seen. The owner's
// data[k] then reaches buf_i one cycle after it is sampled.
// Dropping req[k] (or a forced release) ends ownership; gnt is never more than one-hot.
interface o_buft_bus_sched_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0] gnt;
  logic               buf_i;
  logic               buf_t;
  logic               busy;
  logic               timeout;
  logic [1:0]         state;

  modport master (
    output req, data,
    input  gnt, buf_i, buf_t, busy, timeout, state
  );

  modport slave (
    input  req, data,
    output gnt, buf_i, buf_t, busy, timeout, state
  );
endinterface

// File: rtl/o_buft_bus_sched.sv
// Round-robin scheduler sharing one O_BUFT pad between NUM_REQ requesters,
// with high-Z turnaround between owners and an optional per-grant hold limit.
module o_buft_bus_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input logic               clk,
  input logic               rst,
  o_buft_bus_sched_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  logic [1:0]         state;
  logic [NUM_REQ-1:0] req_q;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [15:0]        hold_cnt;
  logic [3:0]         turn_cnt;
  logic [NUM_REQ-1:0] gnt_r;
  logic               buf_i_r;
  logic               buf_t_r;
  logic               timeout_r;

  logic               win_valid;
  logic [IW-1:0]      win_idx;
  logic [IW:0]        scan;
  logic [IW-1:0]      ptr_next;
  logic               owner_req;
  logic               hold_limit;
  logic               drop;
  logic               force_rel;
  logic [1:0]         after_release;

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, ptr} + (IW+1)'(i);
      if (scan >= (IW+1)'(NUM_REQ)) begin
        scan = scan - (IW+1)'(NUM_REQ);
      end
      if (!win_valid && req_q[scan[IW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
  end

  // A drop always wins over the limit, so a simultaneous drop never pulses timeout.
  always_comb begin
    owner_req     = req_q[owner];
    hold_limit    = (MAX_HOLD != 0) && (hold_cnt == 16'(MAX_HOLD));
    drop          = !owner_req;
    force_rel     = owner_req && hold_limit;
    after_release = (TURN_CYCLES > 0) ? TURN : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      ptr       <= '0;
      owner     <= '0;
      hold_cnt  <= '0;
      turn_cnt  <= '0;
      gnt_r     <= '0;
      buf_i_r   <= 1'b0;
      buf_t_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      req_q     <= bus.req;
      timeout_r <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state    <= DRIVE;
            owner    <= win_idx;
            gnt_r    <= NUM_REQ'(1) << win_idx;
            buf_t_r  <= 1'b1;
            buf_i_r  <= bus.data[win_idx];
            ptr      <= ptr_next;
            hold_cnt <= 16'd1;
          end
        end
        DRIVE: begin
          if (drop || force_rel) begin
            state     <= after_release;
            gnt_r     <= '0;
            buf_t_r   <= 1'b0;
            buf_i_r   <= 1'b0;
            timeout_r <= force_rel;
            hold_cnt  <= '0;
            turn_cnt  <= 4'd1;
          end else begin
            buf_i_r <= bus.data[owner];
            if (hold_cnt != 16'hffff) begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
        end
        TURN: begin
          if (turn_cnt == 4'(TURN_CYCLES)) begin
            state    <= IDLE;
            turn_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt + 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          gnt_r   <= '0;
          buf_t_r <= 1'b0;
          buf_i_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.buf_i   = buf_i_r;
  assign bus.buf_t   = buf_t_r;
  assign bus.timeout = timeout_r;
  assign bus.busy    = (state != IDLE);
  assign bus.state   = state;

  // Pad-safety invariants: one driver at most, and never drive without a grant.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_r));
  a_t_needs_gnt: assert property (@(posedge clk) disable iff (rst) buf_t_r |-> (gnt_r != '0));

endmodule

// File: tb/tb_o_buft_bus_sched.sv
// Directed bench for o_buft_bus_sched: several parameterisations share clk/rst,
// and each scenario task drives one instance and checks it edge by edge.
module tb_o_buft_bus_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  o_buft_bus_sched_if #(.NUM_REQ(4)) if_a ();
  o_buft_bus_sched_if #(.NUM_REQ(4)) if_b ();
  o_buft_bus_sched_if #(.NUM_REQ(4)) if_c ();
  o_buft_bus_sched_if #(.NUM_REQ(4)) if_d ();
  o_buft_bus_sched_if #(.NUM_REQ(4)) if_e ();

  o_buft_bus_sched #(.NUM_REQ(4), .TURN_CYCLES(1), .MAX_HOLD(16)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  o_buft_bus_sched #(.NUM_REQ(4), .TURN_CYCLES(1), .MAX_HOLD(4))  u_b (.clk(clk), .rst(rst), .bus(if_b));
  o_buft_bus_sched #(.NUM_REQ(4), .TURN_CYCLES(3), .MAX_HOLD(16)) u_c (.clk(clk), .rst(rst), .bus(if_c));
  o_buft_bus_sched #(.NUM_REQ(4), .TURN_CYCLES(1), .MAX_HOLD(3))  u_d (.clk(clk), .rst(rst), .bus(if_d));
  o_buft_bus_sched #(.NUM_REQ(4), .TURN_CYCLES(0), .MAX_HOLD(0))  u_e (.clk(clk), .rst(rst), .bus(if_e));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_a.req = '0; if_a.data = '0;
    if_b.req = '0; if_b.data = '0;
    if_c.req = '0; if_c.data = '0;
    if_d.req = '0; if_d.data = '0;
    if_e.req = '0; if_e.data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    if_a.req = 4'hf;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (if_a.gnt !== 4'b0000 || if_a.buf_t !== 1'b0 || if_a.busy !== 1'b0 || if_a.state !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got gnt=%b t=%b busy=%b state=%0d exp gnt=0000 t=0 busy=0 state=0",
                 c, if_a.gnt, if_a.buf_t, if_a.busy, if_a.state);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (if_a.gnt !== 4'b0000 || if_a.buf_t !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_e1 got gnt=%b t=%b exp gnt=0000 t=0", if_a.gnt, if_a.buf_t);
    end
    tick();
    checks++;
    if (if_a.gnt !== 4'b0001 || if_a.buf_t !== 1'b1 || if_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_e2 got gnt=%b t=%b busy=%b exp gnt=0001 t=1 busy=1",
               if_a.gnt, if_a.buf_t, if_a.busy);
    end
  endtask

  task automatic test_single_owner();
    logic [9:0] pat;
    logic       exp_t, exp_i, exp_busy;
    logic [3:0] exp_g;
    pat = 10'b1001011010;
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      if_a.req  = (e <= 5) ? 4'b0100 : 4'b0000;
      if_a.data = {1'b0, pat[e], 2'b00};
      tick();
      exp_t    = (e >= 2 && e <= 6);
      exp_i    = exp_t ? pat[e] : 1'b0;
      exp_g    = exp_t ? 4'b0100 : 4'b0000;
      exp_busy = (e >= 2 && e <= 7);
      checks++;
      if (if_a.buf_t !== exp_t || if_a.buf_i !== exp_i || if_a.gnt !== exp_g || if_a.busy !== exp_busy) begin
        errors++;
        $display("FAIL single_owner e=%0d got t=%b i=%b gnt=%b busy=%b exp t=%b i=%b gnt=%b busy=%b",
                 e, if_a.buf_t, if_a.buf_i, if_a.gnt, if_a.busy, exp_t, exp_i, exp_g, exp_busy);
      end
    end
  endtask

  task automatic test_round_robin_timeout();
    logic [3:0] dat;
    logic [3:0] exp_g;
    logic       exp_t, exp_i, exp_to;
    int         p, k;
    dat = 4'b1010;
    do_reset();
    if_b.req  = 4'hf;
    if_b.data = dat;
    for (int e = 1; e <= 29; e++) begin
      tick();
      if (e < 2) begin
        exp_g = 4'b0000; exp_t = 1'b0; exp_i = 1'b0; exp_to = 1'b0;
      end else begin
        p      = (e - 2) % 6;
        k      = (e - 2) / 6;
        exp_t  = (p < 4);
        exp_g  = exp_t ? 4'(1 << (k % 4)) : 4'b0000;
        exp_i  = exp_t ? dat[k % 4] : 1'b0;
        exp_to = (p == 4);
      end
      checks++;
      if (if_b.gnt !== exp_g || if_b.buf_t !== exp_t || if_b.buf_i !== exp_i || if_b.timeout !== exp_to) begin
        errors++;
        $display("FAIL rr_timeout e=%0d got gnt=%b t=%b i=%b to=%b exp gnt=%b t=%b i=%b to=%b",
                 e, if_b.gnt, if_b.buf_t, if_b.buf_i, if_b.timeout, exp_g, exp_t, exp_i, exp_to);
      end
    end
    if_b.req = '0;
  endtask

  task automatic test_turn_gap();
    logic [3:0] exp_g;
    logic       exp_busy;
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      if_c.req = (e <= 2) ? 4'b0010 : ((e <= 4) ? 4'b1010 : 4'b1000);
      tick();
      exp_g    = (e >= 2 && e <= 5) ? 4'b0010 : ((e == 10) ? 4'b1000 : 4'b0000);
      exp_busy = (e >= 2 && e <= 8) || (e == 10);
      checks++;
      if (if_c.gnt !== exp_g || if_c.buf_t !== (exp_g != 4'b0000) || if_c.busy !== exp_busy) begin
        errors++;
        $display("FAIL turn_gap e=%0d got gnt=%b t=%b busy=%b exp gnt=%b t=%b busy=%b",
                 e, if_c.gnt, if_c.buf_t, if_c.busy, exp_g, (exp_g != 4'b0000), exp_busy);
      end
    end
    if_c.req = '0;
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    if_a.req = 4'b0100;
    tick(); tick(); tick();
    checks++;
    if (if_a.gnt !== 4'b0100 || if_a.buf_t !== 1'b1) begin
      errors++;
      $display("FAIL mid_drive_pre got gnt=%b t=%b exp gnt=0100 t=1", if_a.gnt, if_a.buf_t);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (if_a.gnt !== 4'b0000 || if_a.buf_t !== 1'b0 || if_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_drive_rst got gnt=%b t=%b busy=%b exp gnt=0000 t=0 busy=0",
               if_a.gnt, if_a.buf_t, if_a.busy);
    end
    rst = 1'b0;
    if_a.req = 4'b0110;
    tick();
    tick();
    checks++;
    if (if_a.gnt !== 4'b0010 || if_a.buf_t !== 1'b1) begin
      errors++;
      $display("FAIL mid_drive_regrant got gnt=%b t=%b exp gnt=0010 t=1", if_a.gnt, if_a.buf_t);
    end
    // Requester 3 pending distinguishes a cleared pointer from one left at 3.
    do_reset();
    if_a.req = 4'b0100;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_a.req = 4'b1100;
    tick();
    tick();
    checks++;
    if (if_a.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL mid_drive_ptr_cleared got gnt=%b exp gnt=0100", if_a.gnt);
    end
    if_a.req = '0;
  endtask

  task automatic test_drop_at_limit();
    logic       exp_t;
    logic [3:0] exp_g;
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      if_d.req = (e <= 3) ? 4'b0001 : 4'b0000;
      tick();
      exp_t = (e >= 2 && e <= 4);
      exp_g = exp_t ? 4'b0001 : 4'b0000;
      checks++;
      if (if_d.gnt !== exp_g || if_d.buf_t !== exp_t || if_d.timeout !== 1'b0) begin
        errors++;
        $display("FAIL drop_at_limit e=%0d got gnt=%b t=%b to=%b exp gnt=%b t=%b to=0",
                 e, if_d.gnt, if_d.buf_t, if_d.timeout, exp_g, exp_t);
      end
    end
  endtask

  task automatic test_no_turn_unlimited();
    logic [3:0] exp_g;
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      if_e.req = (e <= 21) ? 4'b0011 : 4'b0010;
      tick();
      exp_g = (e >= 2 && e <= 22) ? 4'b0001 : ((e == 24) ? 4'b0010 : 4'b0000);
      checks++;
      if (if_e.gnt !== exp_g || if_e.timeout !== 1'b0 || if_e.busy !== (exp_g != 4'b0000)) begin
        errors++;
        $display("FAIL no_turn e=%0d got gnt=%b to=%b busy=%b exp gnt=%b to=0 busy=%b",
                 e, if_e.gnt, if_e.timeout, if_e.busy, exp_g, (exp_g != 4'b0000));
      end
    end
    if_e.req = '0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_owner();
    test_round_robin_timeout();
    test_turn_gap();
    test_reset_mid_drive();
    test_drop_at_limit();
    test_no_turn_unlimited();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
